// File: rtl/graph_pkg.sv
// graph_pkg: shared FSM encoding and address-width constants for neighbor_fetch
package graph_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PROC_BITS_DEF = 4;
  localparam int unsigned ADDR_W = WORD_W + PROC_BITS_DEF;
  typedef enum logic [2:0] {IDLE, PTR_LO, PTR_HI, PTR_WAIT, STREAM, DRAIN} state_e;
  function automatic int unsigned addr_w(input int unsigned proc_bits);
    return WORD_W + proc_bits;
  endfunction
endpackage

// File: rtl/nbr_fifo.sv
// nbr_fifo: synchronous FIFO holding neighbour beats {last, tag, data}
// ports: push_i/wdata_i write side, pop_i/rdata_o read side (rdata_o is the head), empty_o, count_o occupancy
module nbr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop, full;
  assign empty_o = cnt_q == '0;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rp_q];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + PW'(do_push);
      rp_q <= rp_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/neighbor_fetch.sv
// neighbor_fetch: reads a vertex's CSR row pointers, then streams its neighbour ids through a credit-limited FIFO
// ports: req_* request handshake, idx_* pointer-memory reads, data_* edge-memory reads (2-cycle latency),
//        nbr_* neighbour stream, done_valid/done_degree completion pulse, err sticky bad-row flag
module neighbor_fetch
  import graph_pkg::*;
#(
  parameter int PROC_BITS = PROC_BITS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [31:0]                 req_vertex,
  input  logic [PROC_BITS-1:0]        req_proc,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [WORD_W+PROC_BITS-1:0] idx_addr,
  output logic                        idx_validin,
  input  logic [31:0]                 rowidx_in,
  output logic [WORD_W+PROC_BITS-1:0] data_addr,
  output logic                        data_validin,
  input  logic [31:0]                 data_in,
  output logic [31:0]                 nbr_data,
  output logic [PROC_BITS-1:0]        nbr_proc,
  output logic                        nbr_valid,
  input  logic                        nbr_ready,
  output logic                        nbr_last,
  output logic                        done_valid,
  output logic [31:0]                 done_degree,
  output logic                        err
);
  localparam int AW = addr_w(PROC_BITS);
  localparam int FW = WORD_W + PROC_BITS + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [31:0] v_q, v_d, start_q, start_d, deg_q, deg_d, i_q, i_d;
  logic [PROC_BITS-1:0] tag_q, tag_d;
  logic err_q, err_d;
  // read-tracking shift register: valid, data-read, pointer-hi word, last-edge per stage
  logic [1:0] sv_q, sd_q, shi_q, sl_q;
  logic [1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic credit_ok, ptr_ret, end_ret, push, pop, last_issue, backwards;
  assign inflight = {1'b0, sd_q[0]} + {1'b0, sd_q[1]};
  // issuing only while buffered + in-flight stays below depth guarantees every return has a slot
  assign credit_ok = 32'(fifo_cnt) + 32'(inflight) < 32'(FIFO_DEPTH);
  assign ptr_ret = sv_q[1] && !sd_q[1];
  assign end_ret = ptr_ret && shi_q[1];
  assign backwards = rowidx_in < start_q;
  assign last_issue = i_q == deg_q - 32'd1;
  assign push = sv_q[1] && sd_q[1];
  assign pop = nbr_valid && nbr_ready;
  assign req_ready = state_q == IDLE;
  assign idx_validin = state_q == PTR_LO || state_q == PTR_HI;
  assign idx_addr = idx_validin ? AW'({tag_q, state_q == PTR_HI ? v_q + 32'd1 : v_q}) : '0;
  assign data_validin = state_q == STREAM && credit_ok;
  assign data_addr = data_validin ? AW'({tag_q, start_q + i_q}) : '0;
  assign nbr_valid = !fifo_empty;
  assign nbr_data = nbr_valid ? fifo_rdata[WORD_W-1:0] : '0;
  assign nbr_proc = nbr_valid ? fifo_rdata[WORD_W +: PROC_BITS] : '0;
  assign nbr_last = nbr_valid && fifo_rdata[FW-1];
  assign done_valid = state_q == DRAIN && inflight == 2'd0 && fifo_empty;
  assign done_degree = done_valid ? deg_q : '0;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    tag_d = tag_q;
    start_d = ptr_ret && !shi_q[1] ? rowidx_in : start_q;
    deg_d = deg_q;
    i_d = i_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          v_d = req_vertex;
          tag_d = req_proc;
          state_d = PTR_LO;
        end
      end
      PTR_LO: state_d = PTR_HI;
      PTR_HI: state_d = PTR_WAIT;
      PTR_WAIT: begin
        if (end_ret) begin
          err_d = err_q || backwards;
          deg_d = backwards ? '0 : rowidx_in - start_q;
          i_d = '0;
          state_d = backwards || rowidx_in == start_q ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (data_validin) begin
          i_d = i_q + 32'd1;
          state_d = last_issue ? DRAIN : STREAM;
        end
      end
      DRAIN: state_d = done_valid ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      v_q <= '0;
      tag_q <= '0;
      start_q <= '0;
      deg_q <= '0;
      i_q <= '0;
      err_q <= 1'b0;
      sv_q <= '0;
      sd_q <= '0;
      shi_q <= '0;
      sl_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      tag_q <= tag_d;
      start_q <= start_d;
      deg_q <= deg_d;
      i_q <= i_d;
      err_q <= err_d;
      sv_q <= {sv_q[0], idx_validin || data_validin};
      sd_q <= {sd_q[0], data_validin};
      shi_q <= {shi_q[0], state_q == PTR_HI};
      sl_q <= {sl_q[0], data_validin && last_issue};
    end
  end
  nbr_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .push_i(push),
    .wdata_i({sl_q[1], tag_q, data_in}),
    .pop_i(pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );
endmodule

// File: tb/tb_neighbor_fetch.sv
// tb_neighbor_fetch: randomized scoreboard bench with CSR memory model for neighbor_fetch
module tb_neighbor_fetch;
  import graph_pkg::*;
  localparam int PB = 4;
  localparam int DEPTH = 4;
  localparam int AW = ADDR_W;
  logic clk_in = 0;
  logic rst_in = 1;
  logic [31:0] req_vertex = 0;
  logic [PB-1:0] req_proc = 0;
  logic req_valid = 0;
  logic req_ready;
  logic [AW-1:0] idx_addr, data_addr;
  logic idx_validin, data_validin;
  logic [31:0] rowidx_in = 0;
  logic [31:0] data_in = 0;
  logic [31:0] nbr_data;
  logic [PB-1:0] nbr_proc;
  logic nbr_valid, nbr_last, done_valid, err;
  logic nbr_ready = 1;
  logic [31:0] done_degree;
  neighbor_fetch #(.PROC_BITS(PB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_vertex(req_vertex), .req_proc(req_proc), .req_valid(req_valid), .req_ready(req_ready),
    .idx_addr(idx_addr), .idx_validin(idx_validin), .rowidx_in(rowidx_in),
    .data_addr(data_addr), .data_validin(data_validin), .data_in(data_in),
    .nbr_data(nbr_data), .nbr_proc(nbr_proc), .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
    .nbr_last(nbr_last), .done_valid(done_valid), .done_degree(done_degree), .err(err)
  );
  always #5 clk_in = ~clk_in;
  typedef struct { logic [31:0] data; logic [PB-1:0] tag; logic last; } beat_t;
  typedef struct { logic [31:0] deg; logic err; } done_t;
  beat_t beat_q[$];
  done_t done_q[$];
  beat_t mb;
  done_t md;
  logic [31:0] ptr_mem [64];
  logic [31:0] edge_mem [256];
  logic err_model = 0;
  logic [PB-1:0] cur_tag = 0;
  int out_cnt = 0;
  int rdy_mode = 1;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // memories answer two cycles after the strobe cycle
  logic [AW:0] cur_i = 0, p1_i = 0, p2_i = 0, cur_d = 0, p1_d = 0, p2_d = 0;
  always @(negedge clk_in) begin
    cur_i = {idx_validin, idx_addr};
    cur_d = {data_validin, data_addr};
  end
  always @(posedge clk_in) begin
    #1;
    p2_i = p1_i;
    p1_i = cur_i;
    p2_d = p1_d;
    p1_d = cur_d;
    rowidx_in = p2_i[AW] ? ptr_mem[p2_i[5:0]] : 32'hDEAD_BEEF;
    data_in = p2_d[AW] ? edge_mem[p2_d[7:0]] : 32'hBAD0_BAD0;
  end
  always @(posedge clk_in) begin
    #1;
    nbr_ready = rdy_mode == 0 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
  end
  logic hold_q = 0;
  logic [31:0] hold_data = 0;
  always @(negedge clk_in) begin
    if (rst_in) hold_q = 0;
    else begin
      if (hold_q) chk("hold_stable", nbr_data, hold_data);
      hold_q = nbr_valid && !nbr_ready;
      hold_data = nbr_data;
      if (idx_validin) chk("idx_tag", idx_addr[AW-1:32], cur_tag);
      if (data_validin) begin
        chk("data_tag", data_addr[AW-1:32], cur_tag);
        chk("credit", out_cnt + 1 <= DEPTH, 1);
      end
      if (nbr_valid && nbr_ready) begin
        if (beat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h expected none", nbr_data);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_data", nbr_data, mb.data);
          chk("beat_tag", nbr_proc, mb.tag);
          chk("beat_last", nbr_last, mb.last);
        end
      end
      if (done_valid) begin
        if (done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got degree %0d expected no pulse", done_degree);
        end else begin
          md = done_q.pop_front();
          chk("done_degree", done_degree, md.deg);
          chk("done_err", err, md.err);
          chk("done_beats_left", beat_q.size(), 0);
        end
      end
      if (req_ready) chk("req_ready_idle", done_q.size(), 0);
      out_cnt += int'(data_validin) - int'(nbr_valid && nbr_ready);
    end
  end
  task automatic issue(input logic [31:0] v, input logic [PB-1:0] tag);
    logic [31:0] s, e, d, vn;
    int t = 0;
    while (!req_ready && t < 500) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: got req_ready 0 expected 1 within 500 cycles");
      return;
    end
    req_vertex = v;
    req_proc = tag;
    req_valid = 1;
    @(posedge clk_in);
    #1;
    req_valid = 0;
    cur_tag = tag;
    vn = v + 32'd1;
    s = ptr_mem[v[5:0]];
    e = ptr_mem[vn[5:0]];
    if (e < s) begin
      err_model = 1;
      d = 0;
    end else d = e - s;
    for (int i = 0; i < int'(d); i++) begin
      mb.data = edge_mem[8'(s + 32'(i))];
      mb.tag = tag;
      mb.last = i == int'(d) - 1;
      beat_q.push_back(mb);
    end
    md.deg = d;
    md.err = err_model;
    done_q.push_back(md);
  endtask
  task automatic wait_done(input int max);
    int t = 0;
    while ((done_q.size() != 0 || beat_q.size() != 0) && t < max) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    if (done_q.size() != 0 || beat_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got %0d beats %0d dones pending expected 0", beat_q.size(), done_q.size());
      beat_q.delete();
      done_q.delete();
    end
  endtask
  task automatic do_reset();
    rst_in = 1;
    beat_q.delete();
    done_q.delete();
    out_cnt = 0;
    err_model = 0;
    @(posedge clk_in);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_nbr_valid", nbr_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {idx_validin, data_validin}, 0);
    chk("rst_addrs", {idx_addr, data_addr}, 0);
    rst_in = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    logic [31:0] v;
    for (int k = 0; k < 64; k++) ptr_mem[k] = 0;
    for (int k = 0; k < 256; k++) edge_mem[k] = $urandom;
    @(posedge clk_in);
    #1;
    do_reset();
    ptr_mem[5] = 10;
    ptr_mem[6] = 13;
    edge_mem[10] = 7;
    edge_mem[11] = 8;
    edge_mem[12] = 9;
    issue(5, 2);
    wait_done(200);
    ptr_mem[2] = 4;
    ptr_mem[3] = 4;
    issue(2, 1);
    wait_done(200);
    chk("err_after_zero", err, 0);
    ptr_mem[1] = 20;
    ptr_mem[2] = 15;
    issue(1, 5);
    wait_done(200);
    repeat (5) @(posedge clk_in);
    #1;
    chk("err_sticky", err, 1);
    do_reset();
    ptr_mem[8] = 30;
    ptr_mem[9] = 40;
    rdy_mode = 2;
    @(posedge clk_in);
    #1;
    issue(8, 6);
    repeat (20) @(posedge clk_in);
    #1;
    chk("stall_outstanding", out_cnt, DEPTH);
    chk("stall_no_issue", data_validin, 0);
    chk("stall_valid", nbr_valid, 1);
    rdy_mode = 1;
    wait_done(300);
    ptr_mem[12] = 50;
    ptr_mem[13] = 58;
    issue(12, 7);
    t = 0;
    while (!data_validin && t < 50) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    chk("stream_reached", data_validin, 1);
    @(posedge clk_in);
    #1;
    do_reset();
    repeat (6) @(posedge clk_in);
    #1;
    chk("post_rst_nbr_valid", nbr_valid, 0);
    issue(12, 7);
    wait_done(300);
    ptr_mem[20] = 60;
    ptr_mem[21] = 64;
    ptr_mem[22] = 70;
    rdy_mode = 0;
    issue(20, 3);
    chk("busy_req_ready", req_ready, 0);
    issue(21, 9);
    wait_done(500);
    ptr_mem[63] = 100;
    ptr_mem[0] = 103;
    issue(32'hFFFF_FFFF, 4);
    wait_done(300);
    for (int n = 0; n < 25; n++) begin
      v = 32'($urandom_range(0, 62));
      ptr_mem[v[5:0]] = 32'($urandom_range(6, 200));
      ptr_mem[v[5:0] + 6'd1] = $urandom_range(0, 7) == 0 ? ptr_mem[v[5:0]] - 32'($urandom_range(1, 5))
                                                         : ptr_mem[v[5:0]] + 32'($urandom_range(0, 12));
      rdy_mode = $urandom_range(0, 1);
      issue(v, 4'($urandom));
      wait_done(500);
      if (n == 12) do_reset();
    end
    repeat (5) @(posedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
